// File: rtl/thresh_ctrl.sv
// ---------------------------------------------------------------------------
// thresh_ctrl
//
// Run-time configuration and sequencing controller for the YCbCr skin
// threshold stage. It sits between the colour-conversion output and the
// binary-mask consumers.
//
// The controller keeps a shadow set of four thresholds {Ta,Tb,Tc,Td}. These
// are written over a valid/ready interface. A commit request arms a transfer
// of the shadow set into the active set. The transfer happens only at the next
// frame boundary (rising edge of v_sync_in), so every frame is thresholded
// with one consistent set of limits.
//
// Datapath: two register stages.
//   stage 1 : bin1 = Cb in (Ta,Tb) and Cr in (Tc,Td), strict unsigned compares
//   stage 2 : pixel_out = {3{bin1 ? 8'hFF : 8'h00}}
// The data enable and both syncs are delayed alongside the data, so the mask
// stays aligned with its timing signals.
//
// Optional feature (macro THRESH_STATS_EN):
//   This feature counts de-qualified mask pixels in each frame. At every
//   frame boundary seen at stage 1, it reports the total on mask_count and
//   pulses mask_count_valid for one cycle. Without the macro, both ports are
//   tied to 0.
//
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   pixel_in[23:0]      {Y, Cb, Cr}
//   de_in               data enable
//   h_sync_in           horizontal sync, active high
//   v_sync_in           vertical sync, active high
//   pixel_out[23:0]     binary mask replicated on all three channels
//   de_out              de_in delayed 2 cycles
//   h_sync_out          h_sync_in delayed 2 cycles
//   v_sync_out          v_sync_in delayed 2 cycles
//   cfg_valid           config write request
//   cfg_ready           controller accepts a write this cycle
//   cfg_sel[1:0]        0=Ta, 1=Tb, 2=Tc, 3=Td
//   cfg_data[7:0]       threshold value
//   cfg_commit          with an accepted write, arms an apply at next frame
//   cfg_pending         commit armed, not yet applied
//   cfg_applied         one-cycle pulse while the active set is being updated
//   thr_active[31:0]    {Ta,Tb,Tc,Td} currently in use
//   mask_count          mask pixels in the last frame (THRESH_STATS_EN)
//   mask_count_valid    pulse when mask_count updates (THRESH_STATS_EN)
// ---------------------------------------------------------------------------
module thresh_ctrl #(
  parameter logic [7:0] TA_INIT = 8'd110,
  parameter logic [7:0] TB_INIT = 8'd140,
  parameter logic [7:0] TC_INIT = 8'd145,
  parameter logic [7:0] TD_INIT = 8'd180,
  parameter int         CNT_W   = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      pixel_in,
  input  logic             de_in,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  output logic [23:0]      pixel_out,
  output logic             de_out,
  output logic             h_sync_out,
  output logic             v_sync_out,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_sel,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_commit,
  output logic             cfg_pending,
  output logic             cfg_applied,
  output logic [31:0]      thr_active,
  output logic [CNT_W-1:0] mask_count,
  output logic             mask_count_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STAGED,
    S_ARMED,
    S_APPLY
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_vsync_prev;
  logic        w_frame_edge;
  logic        w_ready;
  logic        w_accept;

  logic [7:0]  r_shadow_ta;
  logic [7:0]  r_shadow_tb;
  logic [7:0]  r_shadow_tc;
  logic [7:0]  r_shadow_td;

  logic [7:0]  r_active_ta;
  logic [7:0]  r_active_tb;
  logic [7:0]  r_active_tc;
  logic [7:0]  r_active_td;

  logic [7:0]  w_cb;
  logic [7:0]  w_cr;
  logic        w_in_range;
  logic        w_unused_luma;

  logic        r_bin1;
  logic        r_de1;
  logic        r_hs1;
  logic        r_vs1;

  logic [23:0] r_pix2;
  logic        r_de2;
  logic        r_hs2;
  logic        r_vs2;

  // Frame boundary detection. We keep a registered copy of v_sync_in, so a
  // boundary is the single cycle where the sync is high now but was low in
  // the previous cycle. Reset clears the copy. As a result, a sync that is
  // already high when reset is released counts as a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vsync_prev <= 1'b0;
    end else begin
      r_vsync_prev <= v_sync_in;
    end
  end

  assign w_frame_edge = v_sync_in & ~r_vsync_prev;

  // Writes are only taken while the controller is out of reset and not
  // waiting on or performing an apply. While armed, the shadow set is
  // frozen. This guarantees that the values applied at the boundary are
  // exactly those present when the commit was accepted.
  assign w_ready  = rst_n & ((r_state == S_IDLE) | (r_state == S_STAGED));
  assign w_accept = cfg_valid & w_ready;
  assign cfg_ready = w_ready;

  // Shadow threshold set. An accepted write lands here on the same edge that
  // the FSM sees it. A write that also carries a commit is therefore already
  // part of the set that the later apply copies.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow_ta <= TA_INIT;
      r_shadow_tb <= TB_INIT;
      r_shadow_tc <= TC_INIT;
      r_shadow_td <= TD_INIT;
    end else if (w_accept) begin
      case (cfg_sel)
        2'd0:    r_shadow_ta <= cfg_data;
        2'd1:    r_shadow_tb <= cfg_data;
        2'd2:    r_shadow_tc <= cfg_data;
        default: r_shadow_td <= cfg_data;
      endcase
    end
  end

  // Sequencer state register. Reset returns the FSM to IDLE, which throws
  // away any commit that was armed but not yet applied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Sequencer next-state and status outputs.
  // - A commit only arms the controller.
  // - The apply is triggered by the first boundary seen while already in
  //   ARMED. A boundary on the same edge as the commit is therefore skipped.
  // - APPLY lasts exactly one cycle. The copy into the active set happens on
  //   the edge that leaves APPLY.
  always_comb begin
    w_next_state = r_state;
    cfg_pending  = 1'b0;
    cfg_applied  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = cfg_commit ? S_ARMED : S_STAGED;
        end
      end
      S_STAGED: begin
        if (w_accept && cfg_commit) begin
          w_next_state = S_ARMED;
        end
      end
      S_ARMED: begin
        cfg_pending = 1'b1;
        if (w_frame_edge) begin
          w_next_state = S_APPLY;
        end
      end
      S_APPLY: begin
        cfg_applied  = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Active threshold set. It changes only on the edge that ends the APPLY
  // cycle. Because APPLY always follows a v_sync rising edge, the swap falls
  // inside vertical blanking. The first pixel sampled after this edge uses
  // the new limits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active_ta <= TA_INIT;
      r_active_tb <= TB_INIT;
      r_active_tc <= TC_INIT;
      r_active_td <= TD_INIT;
    end else if (r_state == S_APPLY) begin
      r_active_ta <= r_shadow_ta;
      r_active_tb <= r_shadow_tb;
      r_active_tc <= r_shadow_tc;
      r_active_td <= r_shadow_td;
    end
  end

  assign thr_active = {r_active_ta, r_active_tb, r_active_tc, r_active_td};

  // Luma plays no part in the skin decision. It is reduced here only so the
  // upper byte of the pixel bus is visibly accounted for.
  assign w_unused_luma = ^pixel_in[23:16];

  assign w_cb = pixel_in[15:8];
  assign w_cr = pixel_in[7:0];

  // All four comparisons are strict. Inverted or equal limits therefore
  // produce an empty window and an all-black mask, with no special casing.
  assign w_in_range = (w_cb > r_active_ta) && (w_cb < r_active_tb) &&
                      (w_cr > r_active_tc) && (w_cr < r_active_td);

  // Stage 1: register the decision together with the timing signals. The
  // mask is computed regardless of de, and blanking pixels pass through
  // unchanged in timing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin1 <= 1'b0;
      r_de1  <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
    end else begin
      r_bin1 <= w_in_range;
      r_de1  <= de_in;
      r_hs1  <= h_sync_in;
      r_vs1  <= v_sync_in;
    end
  end

  // Stage 2: expand the one-bit decision to a full-scale pixel and delay
  // the timing signals once more. This gives every output exactly two
  // cycles of latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pix2 <= 24'h000000;
      r_de2  <= 1'b0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
    end else begin
      r_pix2 <= {3{r_bin1 ? 8'hFF : 8'h00}};
      r_de2  <= r_de1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
    end
  end

  assign pixel_out  = r_pix2;
  assign de_out     = r_de2;
  assign h_sync_out = r_hs2;
  assign v_sync_out = r_vs2;

`ifdef THRESH_STATS_EN
  logic             r_vs1_prev;
  logic             w_stage1_edge;
  logic             w_hit;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] r_mask_count;
  logic             r_mask_valid;

  // Statistics run on stage-1 values. This way, the frame boundary and the
  // pixels it closes are judged against the same thresholds that produced
  // the mask.
  assign w_stage1_edge = r_vs1 & ~r_vs1_prev;
  assign w_hit         = r_de1 & r_bin1;

  // Saturating increment. Once all-ones is reached, the counter holds there
  // instead of wrapping back to a misleadingly small value.
  assign w_cnt_next = (w_hit && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;

  // Per-frame mask counter. At a stage-1 frame boundary:
  // - the total, including any hit on that same cycle, is published;
  // - the valid strobe pulses for one cycle;
  // - counting restarts at zero for the new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs1_prev   <= 1'b0;
      r_cnt        <= '0;
      r_mask_count <= '0;
      r_mask_valid <= 1'b0;
    end else begin
      r_vs1_prev <= r_vs1;
      if (w_stage1_edge) begin
        r_mask_count <= w_cnt_next;
        r_mask_valid <= 1'b1;
        r_cnt        <= '0;
      end else begin
        r_mask_valid <= 1'b0;
        r_cnt        <= w_cnt_next;
      end
    end
  end

  assign mask_count       = r_mask_count;
  assign mask_count_valid = r_mask_valid;
`else
  // Statistics are not built. The ports stay so the interface matches the
  // full build.
  assign mask_count       = '0;
  assign mask_count_valid = 1'b0;
`endif

endmodule

// File: doc/thresh_ctrl.md
Name: thresh_ctrl

Overview:
- Run-time configuration and sequencing controller for the YCbCr skin-threshold stage of the vision pipeline; sits between the colour-conversion output and the downstream binary-mask consumers.
- Holds the four thresholds (Cb lower/upper, Cr lower/upper) in shadow registers written over a valid/ready interface.
- Swaps shadow thresholds into the active set only at a frame boundary, so no frame is thresholded with mixed limits.
- Contains the registered threshold datapath with sync/enable alignment.

Parameters:
- TA_INIT, 110, reset value of Cb lower bound (exclusive)
- TB_INIT, 140, reset value of Cb upper bound (exclusive)
- TC_INIT, 145, reset value of Cr lower bound (exclusive)
- TD_INIT, 180, reset value of Cr upper bound (exclusive)
- CNT_W, 22, width of mask pixel counter (optional feature only)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- pixel_in  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}
- de_in  in  1  data enable
- h_sync_in  in  1  horizontal sync, active high
- v_sync_in  in  1  vertical sync, active high
- pixel_out  out  24  {bin,bin,bin}, bin = 8'd255 or 8'd0
- de_out  out  1  de_in delayed 2 cycles
- h_sync_out  out  1  h_sync_in delayed 2 cycles
- v_sync_out  out  1  v_sync_in delayed 2 cycles
- cfg_valid  in  1  config write request
- cfg_ready  out  1  controller accepts a write this cycle
- cfg_sel  in  2  0=Ta, 1=Tb, 2=Tc, 3=Td
- cfg_data  in  8  threshold value
- cfg_commit  in  1  qualified by cfg_valid; arms an apply at the next frame boundary
- cfg_pending  out  1  commit armed, not yet applied
- cfg_applied  out  1  one-cycle pulse when the active set is updated
- thr_active  out  32  {Ta,Tb,Tc,Td} currently in use
- mask_count  out  CNT_W  mask pixels in last frame (optional feature)
- mask_count_valid  out  1  one-cycle pulse when mask_count updates (optional feature)

Behaviour:
- Reset (rst_n low at a clk edge): active and shadow sets = *_INIT; state IDLE; cfg_ready=0 while rst_n low; all pipeline regs, pixel_out, de_out, h_sync_out, v_sync_out, cfg_pending, cfg_applied = 0; v_sync edge detector cleared. Reset mid-frame or mid-ARMED discards any pending commit.
- Frame boundary: v_sync_in=1 this cycle and 0 the previous cycle (rising edge, from a registered copy).
- Write accept: cfg_valid && cfg_ready. The shadow register selected by cfg_sel takes cfg_data at that edge.
- FSM:
  - IDLE: cfg_ready=1. Accepted write without commit -> STAGED. Accepted write with commit -> ARMED (the write lands in the shadow set first).
  - STAGED: cfg_ready=1. Further writes stay in STAGED. Accepted write with commit -> ARMED.
  - ARMED: cfg_ready=0, cfg_pending=1. cfg_valid is ignored. Next frame boundary -> APPLY. A boundary in the same cycle as the commit accept does not count; the next boundary is used.
  - APPLY: one cycle. Shadow copied to active; cfg_applied=1; cfg_pending=0; cfg_ready=0 -> IDLE.
- A commit from IDLE with no new data re-applies identical values (legal).
- No range check on values. Ta>=Tb or Tc>=Td yields an all-zero mask.
- Datapath:
  - Stage 1 registers the compare bin1 = (Cb>Ta && Cb<Tb && Cr>Tc && Cr<Td), all comparisons strict and 8-bit unsigned, using the active set. It also registers de, h_sync and v_sync.
  - Stage 2 registers pixel_out = {3{bin1 ? 8'hFF : 8'h00}} and the delayed syncs.
  - Latency is exactly 2 cycles. The mask is produced irrespective of de.
  - The new active set is used from the first pixel sampled after the APPLY edge. Because the apply follows the v_sync edge, it lands in vertical blanking.

Optional Feature:
- Macro THRESH_STATS_EN.
- Defined:
  - A CNT_W counter increments when stage-1 de && bin1; it saturates at all-ones.
  - At each frame boundary seen at stage 1 (delayed v_sync rising edge), mask_count takes the counter value (including a hit on that cycle), mask_count_valid pulses for one cycle, and the counter restarts from 0.
  - Reset clears the counter, mask_count and mask_count_valid.
- Not defined: mask_count and mask_count_valid are driven constant 0; the ports remain so the interface is unchanged.

Test Plan:
- Release reset -> thr_active=32'h6E8C91B4, cfg_ready=1 next cycle; pixel_in=24'h007898 (Cb=120, Cr=152) with de_in=1 -> pixel_out=24'hFFFFFF exactly 2 cycles later, de_out follows.
- Boundaries with default limits: Cb=110 or Cb=140 or Cr=145 or Cr=180 -> pixel_out=0; Cb=111, Cr=179 -> 24'hFFFFFF.
- Mid-frame write Ta=130 with commit -> cfg_pending=1, cfg_ready=0, Cb=120 pixels stay white until the v_sync rising edge; cfg_applied pulses the cycle after the edge, thr_active[31:24]=130, Cb=120 then black.
- While ARMED, drive cfg_valid with Td=50 -> write ignored, thr_active[7:0] stays 180 after the apply.
- Commit accepted on the same edge as a v_sync rising edge -> no apply on that edge; apply follows the next frame's edge.
- THRESH_STATS_EN defined: frame with 37 de-qualified in-range pixels -> mask_count=37 with one mask_count_valid pulse at the following boundary. Without the macro -> both ports stay 0.
